// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, redirect and stall handling.
// Define IF_PERF_CNT_EN to add the fetch_count/redirect_count performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000060,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        ID_pc_mux_sel,
  input  logic [31:0] ID_jmp_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic [31:0] buf_pc, buf_pc_next, buf_instr, buf_instr_next;
  logic        buf_valid, buf_valid_next;
  logic [31:0] ifid_pc_next, ifid_instr_next;
  logic        ifid_valid_next;
  logic [31:0] target;
  logic        accept;
  logic        bubble;

  assign target       = {ID_jmp_pc[31:2], 2'b00};
  assign imem_read    = rst_n && (state != HOLD);
  // While dropping, the abandoned request's address stays on the bus even though pc has moved on.
  assign imem_address = (state == DROP) ? drop_addr : pc;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    drop_addr_next  = drop_addr;
    buf_pc_next     = buf_pc;
    buf_instr_next  = buf_instr;
    buf_valid_next  = buf_valid;
    ifid_pc_next    = IF_ID_pc;
    ifid_instr_next = IF_ID_instr;
    ifid_valid_next = IF_ID_valid;
    accept          = 1'b0;
    bubble          = 1'b0;
    case (state)
      FETCH: begin
        if (ID_pc_mux_sel) begin
          pc_next        = target;
          drop_addr_next = pc;
          state_next     = imem_resp ? FETCH : DROP;
          bubble         = !stall;
        end else if (imem_resp && stall) begin
          buf_pc_next    = pc;
          buf_instr_next = imem_rdata;
          buf_valid_next = 1'b1;
          pc_next        = pc + 32'd4;
          state_next     = HOLD;
          accept         = 1'b1;
        end else if (imem_resp) begin
          ifid_pc_next    = pc;
          ifid_instr_next = imem_rdata;
          ifid_valid_next = 1'b1;
          pc_next         = pc + 32'd4;
          accept          = 1'b1;
        end else begin
          bubble = !stall;
        end
      end
      HOLD: begin
        if (ID_pc_mux_sel) begin
          pc_next        = target;
          buf_valid_next = 1'b0;
          state_next     = FETCH;
          bubble         = !stall;
        end else if (!stall) begin
          ifid_pc_next    = buf_pc;
          ifid_instr_next = buf_instr;
          ifid_valid_next = 1'b1;
          buf_valid_next  = 1'b0;
          state_next      = FETCH;
        end
      end
      DROP: begin
        if (ID_pc_mux_sel) pc_next = target;
        else if (imem_resp) state_next = FETCH;
        bubble = !stall;
      end
      default: state_next = FETCH;
    endcase
    if (bubble) begin
      ifid_valid_next = 1'b0;
      ifid_instr_next = NOP_INSTR;
    end
    if (flush) begin
      ifid_valid_next = 1'b0;
      ifid_instr_next = NOP_INSTR;
      ifid_pc_next    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      drop_addr   <= '0;
      buf_pc      <= '0;
      buf_instr   <= NOP_INSTR;
      buf_valid   <= 1'b0;
      IF_ID_pc    <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      drop_addr   <= drop_addr_next;
      buf_pc      <= buf_pc_next;
      buf_instr   <= buf_instr_next;
      buf_valid   <= buf_valid_next;
      IF_ID_pc    <= ifid_pc_next;
      IF_ID_instr <= ifid_instr_next;
      IF_ID_valid <= ifid_valid_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (ID_pc_mux_sel) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: streaming, stall/hold, redirect/drop, reset, wrap.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        ID_pc_mux_sel;
  logic [31:0] ID_jmp_pc;
  logic        flush;
  logic        stall;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  if_stage #(.RESET_PC(32'h00000060), .NOP_INSTR(32'h00000013)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .ID_pc_mux_sel(ID_pc_mux_sel),
    .ID_jmp_pc    (ID_jmp_pc),
    .flush        (flush),
    .stall        (stall),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_instr  (IF_ID_instr),
    .IF_ID_valid  (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .redirect_count(redirect_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    ID_pc_mux_sel = 1'b0; ID_jmp_pc = '0; flush = 1'b0; stall = 1'b0;
    tick(); tick();
    check("rst_read", imem_read, 0);
    check("rst_addr", imem_address, 32'h60);
    check("rst_pc", IF_ID_pc, 0);
    check("rst_instr", IF_ID_instr, 32'h13);
    check("rst_valid", IF_ID_valid, 0);

    // Streaming with a single-cycle memory returning the address as data
    rst_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h60;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_pc", IF_ID_pc, 32'h60 + 32'(4 * i));
      check("seq_instr", IF_ID_instr, 32'h60 + 32'(4 * i));
      check("seq_valid", IF_ID_valid, 1);
      imem_rdata = imem_address;
    end
    check("seq_addr", imem_address, 32'h6C);

    // Response under stall goes to the hold buffer
    stall = 1'b1;
    tick();
    check("hold_read", imem_read, 0);
    check("hold_pc", IF_ID_pc, 32'h68);
    imem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_read", imem_read, 0);
      check("hold_pc", IF_ID_pc, 32'h68);
      check("hold_instr", IF_ID_instr, 32'h68);
    end
    stall = 1'b0;
    tick();
    check("unhold_pc", IF_ID_pc, 32'h6C);
    check("unhold_instr", IF_ID_instr, 32'h6C);
    check("unhold_valid", IF_ID_valid, 1);
    check("unhold_addr", imem_address, 32'h70);
    check("unhold_read", imem_read, 1);

    // Redirect + flush with request at 0x70 outstanding
    ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'h200; flush = 1'b1;
    tick();
    check("drop_addr", imem_address, 32'h70);
    check("drop_read", imem_read, 1);
    check("drop_valid", IF_ID_valid, 0);
    check("flush_pc", IF_ID_pc, 0);
    ID_pc_mux_sel = 1'b0; flush = 1'b0;
    tick();
    check("drop_addr2", imem_address, 32'h70);
    check("drop_valid2", IF_ID_valid, 0);
    imem_resp = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    check("refetch_addr", imem_address, 32'h200);
    check("refetch_valid", IF_ID_valid, 0);
    check("refetch_instr", IF_ID_instr, 32'h13);

    // Redirect with same-cycle response: discarded, target aligned
    ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'h303; imem_rdata = 32'h00000BAD;
    tick();
    check("redir_addr", imem_address, 32'h300);
    check("redir_valid", IF_ID_valid, 0);
    ID_jmp_pc = 32'h203;
    tick();
    check("align_addr", imem_address, 32'h200);

    // Reset asserted while dropping
    imem_resp = 1'b0; ID_jmp_pc = 32'h400;
    tick();
    check("drop3_addr", imem_address, 32'h200);
    ID_pc_mux_sel = 1'b0; rst_n = 1'b0;
    #1;
    check("rst_drop_read", imem_read, 0);
    tick();
    check("rst2_read", imem_read, 0);
    check("rst2_addr", imem_address, 32'h60);
    check("rst2_pc", IF_ID_pc, 0);
    check("rst2_instr", IF_ID_instr, 32'h13);
    check("rst2_valid", IF_ID_valid, 0);
    rst_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h60;
    tick();
    check("restart_pc", IF_ID_pc, 32'h60);
    check("restart_valid", IF_ID_valid, 1);
    check("restart_addr", imem_address, 32'h64);

    // pc wraps at the top of the address space
    ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'hFFFFFFFE;
    tick();
    check("wrap_target", imem_address, 32'hFFFFFFFC);
    check("wrap_bubble", IF_ID_valid, 0);
    ID_pc_mux_sel = 1'b0; imem_rdata = 32'h12345678;
    tick();
    check("wrap_pc", IF_ID_pc, 32'hFFFFFFFC);
    check("wrap_instr", IF_ID_instr, 32'h12345678);
    check("wrap_addr", imem_address, 0);

    // flush beats stall and leaves pc alone
    imem_resp = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_stall_pc", IF_ID_pc, 0);
    check("flush_stall_valid", IF_ID_valid, 0);
    check("flush_stall_instr", IF_ID_instr, 32'h13);
    check("flush_keep_addr", imem_address, 0);
    stall = 1'b0; flush = 1'b0;

`ifdef IF_PERF_CNT_EN
    rst_n = 1'b0;
    tick();
    check("perf_rst_fetch", fetch_count, 0);
    rst_n = 1'b1; imem_resp = 1'b1;
    repeat (5) tick();
    ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'h100;
    tick();
    imem_resp = 1'b0;
    tick();
    ID_pc_mux_sel = 1'b0;
    tick();
    check("perf_fetch", fetch_count, 5);
    check("perf_redirect", redirect_count, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
